srl_chain_stim: RTL and testbench

- Upstream stimulus stage for the 4x SRLC32E cascade minitest in one slice. It drives that chain's CE, D and A[4:0].
- On START it shifts a deterministic LFSR bit pattern into the chain (FILL). It then holds the data and sweeps the tap address through all 32 taps (SWEEP), so every SRL stage and address decode is exercised.
- Gives the downstream capture logic a known, reproducible sequence with BUSY/DONE framing.

---
 rtl/srl_chain_stim.sv | 139 +++++++++++++
 tb/tb_srl_chain_stim.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srl_chain_stim.sv
// Stimulus generator for a 4x SRLC32E cascade: LFSR fill, then a tap-address sweep.
// Optional macro SRL_STIM_SWEEP_SHIFT_EN adds one shift per address during the sweep.
module srl_chain_stim #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned FILL_LEN  = 128,
  parameter int unsigned DWELL     = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic       CE,
  output logic       D,
  output logic [4:0] A,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] SHIFT_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_SWEEP = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [7:0] FILL_LAST  = 8'(FILL_LEN - 1);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [4:0]  w_a_nxt;
  logic        w_ce_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;
  logic [7:0]  w_shift_base;
  logic [7:0]  w_shift_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = A;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_a_nxt   = '0;
        if (START) begin
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        w_a_nxt = '0;
        if (r_cnt == FILL_LAST) begin
          w_state_nxt = S_SWEEP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_SWEEP: begin
        if (r_cnt == DWELL_LAST) begin
          w_cnt_nxt = '0;
          if (A == 5'd31) begin
            w_state_nxt = S_FIN;
            w_a_nxt     = '0;
          end else begin
            w_a_nxt = A + 5'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_a_nxt     = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_a_nxt     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so their registers line up with the state register.
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_FILL) || (w_state_nxt == S_SWEEP);
    w_done_nxt = (w_state_nxt == S_FIN);
`ifdef SRL_STIM_SWEEP_SHIFT_EN
    w_ce_nxt   = (w_state_nxt == S_FILL) ||
                 ((w_state_nxt == S_SWEEP) && (w_cnt_nxt == DWELL_LAST));
`else
    w_ce_nxt   = (w_state_nxt == S_FILL);
`endif
    // The LFSR steps at the end of every cycle in which CE was presented high.
    w_lfsr_nxt = CE ? {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]}
                    : r_lfsr;
    w_shift_base = ((r_state == S_IDLE) && START) ? '0 : SHIFT_CNT;
    w_shift_nxt  = w_shift_base;
    if (w_ce_nxt && (w_shift_base != '1)) begin
      w_shift_nxt = w_shift_base + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CE        <= 1'b0;
      D         <= 1'b0;
      A         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      SHIFT_CNT <= '0;
      r_lfsr    <= LFSR_SEED;
    end else begin
      CE        <= w_ce_nxt;
      D         <= w_ce_nxt & w_lfsr_nxt[0];
      A         <= w_a_nxt;
      BUSY      <= w_busy_nxt;
      DONE      <= w_done_nxt;
      SHIFT_CNT <= w_shift_nxt;
      r_lfsr    <= w_lfsr_nxt;
    end
  end

endmodule

// File: tb/tb_srl_chain_stim.sv
// Bench for srl_chain_stim: run-offset reference model, per-cycle compare, pinned timeline checks.
module tb_srl_chain_stim;

`ifdef SRL_STIM_SWEEP_SHIFT_EN
  localparam int FL = 4;
  localparam int DW = 2;
  localparam bit SWEEP_SHIFT = 1'b1;
  localparam int PIN_DBITS    = 4;
  localparam int PIN_FILL_END = 14;
  localparam int PIN_SWEEP0   = 15;
  localparam int PIN_A17_CYC  = 49;
  localparam int PIN_DONE     = 79;
  localparam int PIN_CNT_DONE = 36;
  localparam int PIN_CE_S1    = 1;
`else
  localparam int FL = 128;
  localparam int DW = 4;
  localparam bit SWEEP_SHIFT = 1'b0;
  localparam int PIN_DBITS    = 8;
  localparam int PIN_FILL_END = 138;
  localparam int PIN_SWEEP0   = 139;
  localparam int PIN_A17_CYC  = 207;
  localparam int PIN_DONE     = 267;
  localparam int PIN_CNT_DONE = 128;
  localparam int PIN_CE_S1    = 0;
`endif
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int SWEEP_LEN = 32 * DW;
  localparam int TOTAL     = FL + SWEEP_LEN + 1;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       CE;
  logic       D;
  logic [4:0] A;
  logic       BUSY;
  logic       DONE;
  logic [7:0] SHIFT_CNT;

  srl_chain_stim #(
    .LFSR_SEED(SEED),
    .FILL_LEN (FL),
    .DWELL    (DW)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .CE       (CE),
    .D        (D),
    .A        (A),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SHIFT_CNT(SHIFT_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  bit cmp_en = 1'b0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs as a function of t = cycles since the accepted START (0 = idle).
  function automatic bit exp_ce(input int t);
    int s;
    if (t >= 1 && t <= FL) return 1'b1;
    s = t - FL - 1;
    if (t > FL && s < SWEEP_LEN) return SWEEP_SHIFT && ((s % DW) == DW - 1);
    return 1'b0;
  endfunction

  function automatic int exp_a(input int t);
    if (t > FL && t <= FL + SWEEP_LEN) return (t - FL - 1) / DW;
    return 0;
  endfunction

  function automatic bit exp_busy(input int t);
    return (t >= 1) && (t <= FL + SWEEP_LEN);
  endfunction

  function automatic int exp_cnt(input int t);
    int s;
    int n;
    if (t <= FL) return t;
    s = t - FL;
    if (s > SWEEP_LEN) s = SWEEP_LEN;
    n = FL + (SWEEP_SHIFT ? s / DW : 0);
    return (n > 255) ? 255 : n;
  endfunction

  int          m_t    = 0;
  logic [15:0] m_lfsr = SEED;
  int          m_last = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_t    <= 0;
      m_lfsr <= SEED;
      m_last <= 0;
    end else begin
      if (m_t == 0) begin
        m_t <= START ? 1 : 0;
      end else if (m_t == TOTAL) begin
        m_t    <= 0;
        m_last <= exp_cnt(TOTAL);
      end else begin
        m_t <= m_t + 1;
      end
      if (exp_ce(m_t)) m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("CE", 32'(CE), 32'(exp_ce(m_t)));
      check("D", 32'(D), 32'(exp_ce(m_t) ? m_lfsr[0] : 1'b0));
      check("A", 32'(A), exp_a(m_t));
      check("BUSY", 32'(BUSY), 32'(exp_busy(m_t)));
      check("DONE", 32'(DONE), 32'(m_t == TOTAL));
      check("SHIFT_CNT", 32'(SHIFT_CNT), (m_t == 0) ? m_last : exp_cnt(m_t));
      if (DONE === 1'b1) dones++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((BUSY !== 1'b0 || DONE !== 1'b0) && n < 2000) begin
      tick();
      n++;
    end
    check("wait_idle", 32'(BUSY), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int d0;
    int n;
    pat = 8'hE1;

    repeat (2) tick();
    cmp_en = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (50) tick();
    check("idle_ce", 32'(CE), 32'd0);
    check("idle_d", 32'(D), 32'd0);
    check("idle_a", 32'(A), 32'd0);
    check("idle_busy", 32'(BUSY), 32'd0);
    check("idle_done", 32'(DONE), 32'd0);
    check("idle_cnt", 32'(SHIFT_CNT), 32'd0);

    // Pinned run: START high during cycle 10.
    cyc = 0;
    goto_cyc(10);
    START = 1'b1;
    goto_cyc(11);
    START = 1'b0;
    for (int unsigned i = 0; i < PIN_DBITS; i++) begin
      goto_cyc(11 + int'(i));
      check("seed_dbit", 32'(D), 32'(pat[i]));
      check("fill_ce", 32'(CE), 32'd1);
    end
    goto_cyc(PIN_FILL_END);
    check("fill_end_ce", 32'(CE), 32'd1);
    check("fill_end_cnt", 32'(SHIFT_CNT), 32'(PIN_FILL_END - 10));
    goto_cyc(PIN_SWEEP0);
    check("sweep0_ce", 32'(CE), 32'd0);
    check("sweep0_a", 32'(A), 32'd0);
    check("sweep0_busy", 32'(BUSY), 32'd1);
    goto_cyc(PIN_SWEEP0 + 1);
    check("sweep0_ce2", 32'(CE), 32'(PIN_CE_S1));
    goto_cyc(PIN_A17_CYC - 1);
    check("a16_last", 32'(A), 32'd16);
    goto_cyc(PIN_A17_CYC);
    check("a17_first", 32'(A), 32'd17);
    goto_cyc(PIN_DONE - 1);
    check("pre_done_busy", 32'(BUSY), 32'd1);
    check("pre_done_a", 32'(A), 32'd31);
    check("pre_done_done", 32'(DONE), 32'd0);
    goto_cyc(PIN_DONE);
    check("done_pulse", 32'(DONE), 32'd1);
    check("done_busy", 32'(BUSY), 32'd0);
    check("done_a", 32'(A), 32'd0);
    check("done_cnt", 32'(SHIFT_CNT), 32'(PIN_CNT_DONE));

    // Second run started in the first IDLE cycle after FIN, with an ignored re-pulse.
    goto_cyc(PIN_DONE + 1);
    check("post_done", 32'(DONE), 32'd0);
    d0 = dones;
    START = 1'b1;
    goto_cyc(PIN_DONE + 2);
    START = 1'b0;
    check("run2_ce", 32'(CE), 32'd1);
    check("run2_cnt", 32'(SHIFT_CNT), 32'd1);
    goto_cyc(PIN_DONE + 1 + 50);
    START = 1'b1;
    goto_cyc(PIN_DONE + 1 + 51);
    START = 1'b0;
    goto_cyc(PIN_DONE + 1 + TOTAL);
    check("run2_done", 32'(DONE), 32'd1);
    goto_cyc(PIN_DONE + 2 + TOTAL);
    check("run2_one_done", 32'(dones - d0), 32'd1);

    // Random START traffic with occasional one-cycle resets.
    for (int unsigned i = 0; i < 4000; i++) begin
      START = ($urandom_range(0, 24) == 0);
      RST_N = ($urandom_range(0, 1499) != 0);
      tick();
    end
    START = 1'b0;
    RST_N = 1'b1;
    tick();
    wait_idle();

    // Reset while A=17 in SWEEP: async clear, no DONE, LFSR back to seed.
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (A !== 5'd17 && n < 2000) begin
      tick();
      n++;
    end
    check("reach_a17", 32'(A), 32'd17);
    RST_N = 1'b0;
    #1;
    check("async_ce", 32'(CE), 32'd0);
    check("async_a", 32'(A), 32'd0);
    check("async_busy", 32'(BUSY), 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    d0 = dones;
    repeat (SWEEP_LEN + 20) tick();
    check("no_done_after_abort", 32'(dones - d0), 32'd0);
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int unsigned i = 0; i < PIN_DBITS; i++) begin
      check("reseed_dbit", 32'(D), 32'(pat[i]));
      tick();
    end
    wait_idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
